// File: rtl/seq_detector_lock.sv
// Serial pattern detector with period alignment and lock/unlock hysteresis.
// Used as a link / self-test monitor behind a serial sequence generator.
module seq_detector_lock #(
  parameter int unsigned          PAT_LEN    = 6,
  parameter logic [PAT_LEN-1:0]   PATTERN    = 6'b001011,
  parameter int unsigned          LOCK_CNT   = 3,
  parameter int unsigned          UNLOCK_ERR = 2,
  parameter int unsigned          CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_vld,
  input  logic             din,
  output logic             match,
  output logic             locked,
  output logic [1:0]       sync_state,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned PH_W   = $clog2(PAT_LEN);
  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W = $clog2(UNLOCK_ERR + 1);

  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(PAT_LEN - 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(UNLOCK_ERR - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PAT_LEN-2:0] sr_q, sr_d;
  logic [PH_W-1:0]    fill_q, fill_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic [CNT_W-1:0]   frame_q, frame_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic               match_q;

  logic [PAT_LEN-1:0] window;
  logic               full;
  logic               hit;
  logic               boundary;

  // The window includes the incoming bit, so a hit is known on the bit that completes it.
  always_comb begin
    window   = {sr_q, din};
    full     = (fill_q == PH_LAST);
    hit      = din_vld && full && (window == PATTERN);
    boundary = din_vld && (state_q != ST_SEARCH) && (phase_q == PH_LAST);
    sr_d     = din_vld ? window[PAT_LEN-2:0] : sr_q;
    fill_d   = (din_vld && !full) ? fill_q + 1'b1 : fill_q;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    good_d  = good_q;
    miss_d  = miss_q;
    frame_d = frame_q;
    err_d   = err_q;

    if (din_vld && (state_q != ST_SEARCH)) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
    end

    case (state_q)
      ST_SEARCH: begin
        if (hit) begin
          phase_d = '0;
          good_d  = GOOD_W'(1);
          miss_d  = '0;
          state_d = (LOCK_CNT == 1) ? ST_LOCKED : ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        if (boundary) begin
          if (hit) begin
            good_d = good_q + 1'b1;
            if (good_q == GOOD_LAST) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end
          end else begin
            state_d = ST_SEARCH;
            good_d  = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (boundary) begin
          if (hit) begin
            miss_d = '0;
            if (frame_q != CNT_MAX) frame_d = frame_q + 1'b1;
          end else begin
            if (err_q != CNT_MAX) err_d = err_q + 1'b1;
            if (miss_q == MISS_LAST) begin
              state_d = ST_SEARCH;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SEARCH;
      sr_q    <= '0;
      fill_q  <= '0;
      phase_q <= '0;
      good_q  <= '0;
      miss_q  <= '0;
      frame_q <= '0;
      err_q   <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      fill_q  <= fill_d;
      phase_q <= phase_d;
      good_q  <= good_d;
      miss_q  <= miss_d;
      frame_q <= frame_d;
      err_q   <= err_d;
      match_q <= hit;
    end
  end

  assign match      = match_q;
  assign locked     = (state_q == ST_LOCKED);
  assign sync_state = state_q;
  assign frame_cnt  = frame_q;
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_seq_detector_lock.sv
// Bench for seq_detector_lock: directed scenarios plus random traffic against a
// history-based reference model; a second instance with 2-bit counters checks saturation.
module tb_seq_detector_lock;

  localparam int          PAT_LEN    = 6;
  localparam logic [5:0]  PAT        = 6'b001011;
  localparam logic [5:0]  BAD        = 6'b001111;
  localparam int          LOCK_CNT   = 3;
  localparam int          UNLOCK_ERR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din_vld = 1'b0;
  logic       din = 1'b0;
  logic       match, locked;
  logic [1:0] sync_state;
  logic [7:0] frame_cnt, err_cnt;
  logic       s_match, s_locked;
  logic [1:0] s_sync, s_frame, s_err;

  int checks = 0;
  int errors = 0;

  seq_detector_lock #(.PAT_LEN(6), .PATTERN(6'b001011), .LOCK_CNT(3), .UNLOCK_ERR(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .din_vld(din_vld), .din(din),
    .match(match), .locked(locked), .sync_state(sync_state),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  seq_detector_lock #(.PAT_LEN(6), .PATTERN(6'b001011), .LOCK_CNT(3), .UNLOCK_ERR(2), .CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .din_vld(din_vld), .din(din),
    .match(s_match), .locked(s_locked), .sync_state(s_sync),
    .frame_cnt(s_frame), .err_cnt(s_err)
  );

  always #5 clk = ~clk;

  logic [27:0] obs;
  assign obs = {match, locked, sync_state, frame_cnt, err_cnt, s_match, s_locked, s_sync, s_frame, s_err};

  // Reference model: bit history, anchor index of acquisition, plain integer counters.
  bit hist[$];
  int n_bits, anchor, m_state, m_good, m_miss, m_frame, m_err;
  bit m_match;
  bit stim[$];

  task automatic model_reset();
    hist.delete();
    n_bits = 0; anchor = 0; m_state = 0;
    m_good = 0; m_miss = 0; m_frame = 0; m_err = 0; m_match = 0;
  endtask

  task automatic model_step(input bit vld, input bit d);
    bit h;
    h = 0;
    if (vld) begin
      hist.push_back(d);
      if (hist.size() > PAT_LEN) void'(hist.pop_front());
      n_bits++;
      if (hist.size() == PAT_LEN) begin
        h = 1;
        for (int k = 0; k < PAT_LEN; k++) if (hist[k] != PAT[PAT_LEN-1-k]) h = 0;
      end
      if (m_state == 0) begin
        if (h) begin
          anchor = n_bits; m_good = 1; m_miss = 0;
          m_state = (LOCK_CNT == 1) ? 2 : 1;
        end
      end else if ((n_bits - anchor) % PAT_LEN == 0) begin
        if (m_state == 1) begin
          if (h) begin
            m_good++;
            if (m_good >= LOCK_CNT) begin m_state = 2; m_miss = 0; end
          end else begin
            m_state = 0; m_good = 0;
          end
        end else begin
          if (h) begin
            m_miss = 0; m_frame++;
          end else begin
            m_err++; m_miss++;
            if (m_miss >= UNLOCK_ERR) begin m_state = 0; m_miss = 0; end
          end
        end
      end
    end
    m_match = h;
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [27:0] expv();
    logic [7:0] f8, e8;
    logic [1:0] f2, e2, st;
    logic       lk;
    f8 = 8'(sat(m_frame, 255));
    e8 = 8'(sat(m_err, 255));
    f2 = 2'(sat(m_frame, 3));
    e2 = 2'(sat(m_err, 3));
    st = 2'(m_state);
    lk = (m_state == 2);
    return {m_match, lk, st, f8, e8, m_match, lk, st, f2, e2};
  endfunction

  task automatic drive(input bit vld, input bit d);
    din_vld = vld;
    din     = d;
    @(posedge clk);
    model_step(vld, d);
    #1;
  endtask

  task automatic apply_reset();
    din_vld = 1'b0;
    din     = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push_period(input logic [5:0] p);
    for (int k = PAT_LEN - 1; k >= 0; k--) stim.push_back(p[k]);
  endtask

  task automatic test_reset();
    din_vld = 1'b0;
    rst_n   = 1'b0;
    #3;
    checks++;
    if (obs !== 28'd0) begin
      errors++; $display("FAIL reset_hold: observed %h required 0", obs);
    end
    apply_reset();
    checks++;
    if (obs !== 28'd0) begin
      errors++; $display("FAIL reset_release: observed %h required 0", obs);
    end
  endtask

  task automatic test_acquire_lock();
    apply_reset();
    stim.delete();
    repeat (4) push_period(PAT);
    foreach (stim[i]) begin
      drive(1'b1, stim[i]);
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL acquire bit %0d: observed %h required %h", i + 1, obs, expv());
      end
      if (i == 5) begin
        checks++;
        if (sync_state !== 2'd1 || match !== 1'b1) begin
          errors++; $display("FAIL acquire_first_hit: sync_state=%0d match=%0b required 1/1", sync_state, match);
        end
      end
      if (i == 16 || i == 17) begin
        checks++;
        if (locked !== (i == 17) || frame_cnt !== 8'd0) begin
          errors++; $display("FAIL acquire_lock bit %0d: locked=%0b frame_cnt=%0d required %0b/0", i + 1, locked, frame_cnt, i == 17);
        end
      end
      if (i == 23) begin
        checks++;
        if (frame_cnt !== 8'd1) begin
          errors++; $display("FAIL acquire_frame: frame_cnt=%0d required 1", frame_cnt);
        end
      end
    end
  endtask

  task automatic test_single_error();
    stim.delete();
    push_period(BAD);
    push_period(PAT);
    foreach (stim[i]) begin
      drive(1'b1, stim[i]);
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL single_err bit %0d: observed %h required %h", i + 1, obs, expv());
      end
      if (i == 5) begin
        checks++;
        if (err_cnt !== 8'd1 || locked !== 1'b1) begin
          errors++; $display("FAIL single_err_boundary: err_cnt=%0d locked=%0b required 1/1", err_cnt, locked);
        end
      end
    end
    checks++;
    if (frame_cnt !== 8'd2 || locked !== 1'b1) begin
      errors++; $display("FAIL single_err_recover: frame_cnt=%0d locked=%0b required 2/1", frame_cnt, locked);
    end
  endtask

  task automatic test_double_error();
    stim.delete();
    push_period(BAD);
    push_period(BAD);
    repeat (3) push_period(PAT);
    foreach (stim[i]) begin
      drive(1'b1, stim[i]);
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL double_err bit %0d: observed %h required %h", i + 1, obs, expv());
      end
      if (i == 11) begin
        checks++;
        if (locked !== 1'b0 || sync_state !== 2'd0 || err_cnt !== 8'd3) begin
          errors++; $display("FAIL double_err_unlock: locked=%0b state=%0d err_cnt=%0d required 0/0/3", locked, sync_state, err_cnt);
        end
      end
      if (i == 23 || i == 29) begin
        checks++;
        if (locked !== (i == 29)) begin
          errors++; $display("FAIL double_err_relock bit %0d: locked=%0b required %0b", i + 1, locked, i == 29);
        end
      end
    end
  endtask

  task automatic test_vld_toggle();
    int vb;
    apply_reset();
    stim.delete();
    repeat (4) push_period(PAT);
    vb = 0;
    foreach (stim[i]) begin
      drive(1'b1, stim[i]);
      vb++;
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL toggle valid bit %0d: observed %h required %h", vb, obs, expv());
      end
      if (vb == 6 || vb == 18) begin
        checks++;
        if ((vb == 6 && match !== 1'b1) || (vb == 18 && locked !== 1'b1)) begin
          errors++; $display("FAIL toggle_event bit %0d: match=%0b locked=%0b", vb, match, locked);
        end
      end
      drive(1'b0, 1'($urandom));
      checks++;
      if (obs !== expv() || match !== 1'b0) begin
        errors++; $display("FAIL toggle idle after bit %0d: observed %h required %h", vb, obs, expv());
      end
    end
  endtask

  task automatic test_period7();
    logic [6:0] p7;
    int n_match;
    bit seen_lock;
    p7 = 7'b0010110;
    n_match = 0;
    seen_lock = 0;
    apply_reset();
    stim.delete();
    repeat (7) for (int k = 6; k >= 0; k--) stim.push_back(p7[k]);
    stim.push_back(1'b0);
    foreach (stim[i]) begin
      drive(1'b1, stim[i]);
      if (match === 1'b1) n_match++;
      if (locked !== 1'b0) seen_lock = 1;
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL period7 bit %0d: observed %h required %h", i + 1, obs, expv());
      end
    end
    checks++;
    if (n_match != 7 || seen_lock) begin
      errors++; $display("FAIL period7_summary: matches=%0d locked_seen=%0b required 7/0", n_match, seen_lock);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    stim.delete();
    repeat (3) push_period(PAT);
    repeat (5) begin
      push_period(BAD);
      push_period(PAT);
    end
    foreach (stim[i]) begin
      drive(1'b1, stim[i]);
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL saturate bit %0d: observed %h required %h", i + 1, obs, expv());
      end
    end
    checks++;
    if (s_err !== 2'd3 || s_frame !== 2'd3 || err_cnt !== 8'd5 || frame_cnt !== 8'd5 || locked !== 1'b1) begin
      errors++; $display("FAIL saturate_final: s_err=%0d s_frame=%0d err=%0d frame=%0d locked=%0b required 3/3/5/5/1",
                         s_err, s_frame, err_cnt, frame_cnt, locked);
    end
  endtask

  task automatic test_reset_midop();
    checks++;
    if (locked !== 1'b1 || frame_cnt == 8'd0) begin
      errors++; $display("FAIL midreset_pre: locked=%0b frame_cnt=%0d required locked with frames", locked, frame_cnt);
    end
    din_vld = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 28'd0) begin
      errors++; $display("FAIL midreset_async: observed %h required 0", obs);
    end
    model_reset();
    din_vld = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== expv()) begin
      errors++; $display("FAIL midreset_release: observed %h required %h", obs, expv());
    end
  endtask

  task automatic test_random();
    int cyc;
    logic [5:0] p;
    apply_reset();
    cyc = 0;
    for (int n = 0; n < 80; n++) begin
      p = ($urandom_range(0, 4) == 0) ? 6'($urandom) : PAT;
      for (int k = PAT_LEN - 1; k >= 0; k--) begin
        while ($urandom_range(0, 3) == 0) begin
          drive(1'b0, 1'($urandom));
          cyc++;
          checks++;
          if (obs !== expv()) begin
            errors++; $display("FAIL random idle cycle %0d: observed %h required %h", cyc, obs, expv());
          end
        end
        drive(1'b1, p[k]);
        cyc++;
        checks++;
        if (obs !== expv()) begin
          errors++; $display("FAIL random cycle %0d: observed %h required %h", cyc, obs, expv());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_acquire_lock();
    test_single_error();
    test_double_error();
    test_vld_toggle();
    test_period7();
    test_saturation();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
